// File: rtl/rs232_tx_arb.sv
// Round-robin arbiter sharing one byte-wide RS232 serializer between N_REQ requesters.
// Supports locked multi-byte bursts and aborts a transfer when ser_ack never arrives.
module rs232_tx_arb #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 200000,
    parameter int unsigned TO_W    = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   req_lock,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   ack,
    output logic [7:0]         ser_data,
    output logic               ser_req,
    input  logic               ser_ack,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               timeout_err
);

    localparam int unsigned     LW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [LW-1:0]   LAST_IDX = LW'(N_REQ - 1);
    localparam logic [TO_W-1:0] TO_END   = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state, w_state;
    logic [LW-1:0]      r_last, w_last;
    logic               r_lock_own, w_lock_own;
    logic [TO_W-1:0]    r_cnt, w_cnt;
    logic [N_REQ-1:0]   r_ack, w_ack;
    logic [7:0]         r_ser_data, w_ser_data;
    logic               r_ser_req, w_ser_req;
    logic [N_REQ-1:0]   r_grant, w_grant;
    logic               r_busy, w_busy;
    logic               r_to_err, w_to_err;

    logic               w_found;
    logic [LW-1:0]      w_win;
    logic [N_REQ-1:0]   w_win_oh;
    logic [N_REQ-1:0]   w_last_oh;
    logic [7:0]         w_win_data;

    // Winner search: locked owner first, else scan forward from the last owner.
    always_comb begin
        logic [LW-1:0] idx;
        w_found = 1'b0;
        w_win   = r_last;
        idx     = r_last;
        if (r_lock_own && req[r_last]) begin
            w_found = 1'b1;
        end else begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
                if (!w_found && req[idx]) begin
                    w_found = 1'b1;
                    w_win   = idx;
                end
            end
        end
    end

    assign w_win_oh   = N_REQ'(1) << w_win;
    assign w_last_oh  = N_REQ'(1) << r_last;
    assign w_win_data = req_data[{w_win, 3'b000} +: 8];

    // Next-state and next-output logic.
    always_comb begin
        w_state    = r_state;
        w_last     = r_last;
        w_lock_own = r_lock_own;
        w_cnt      = r_cnt;
        w_ack      = '0;
        w_ser_data = r_ser_data;
        w_ser_req  = r_ser_req;
        w_grant    = r_grant;
        w_to_err   = 1'b0;

        case (r_state)
            ARB: begin
                w_grant   = '0;
                w_ser_req = 1'b0;
                if (r_lock_own && !req[r_last]) begin
                    w_lock_own = 1'b0;
                end
                if (w_found) begin
                    w_grant    = w_win_oh;
                    w_ser_data = w_win_data;
                    w_ser_req  = 1'b1;
                    w_cnt      = '0;
                    w_last     = w_win;
                    w_state    = SEND;
                end
            end
            SEND: begin
                w_cnt = r_cnt + 1'b1;
                // An accept on the final timeout cycle still counts as success.
                if (ser_ack) begin
                    w_ser_req  = 1'b0;
                    w_ack      = w_last_oh;
                    w_lock_own = req_lock[r_last];
                    w_state    = DONE;
                end else if (r_cnt == TO_END) begin
                    w_ser_req  = 1'b0;
                    w_ack      = w_last_oh;
                    w_to_err   = 1'b1;
                    w_lock_own = 1'b0;
                    w_state    = DONE;
                end
            end
            DONE: begin
                w_grant = '0;
                w_state = ARB;
            end
            default: begin
                w_grant   = '0;
                w_ser_req = 1'b0;
                w_state   = ARB;
            end
        endcase

        w_busy = (w_state != ARB);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB;
            r_last     <= LAST_IDX;
            r_lock_own <= 1'b0;
            r_cnt      <= '0;
            r_ack      <= '0;
            r_ser_data <= '0;
            r_ser_req  <= 1'b0;
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_to_err   <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_last     <= w_last;
            r_lock_own <= w_lock_own;
            r_cnt      <= w_cnt;
            r_ack      <= w_ack;
            r_ser_data <= w_ser_data;
            r_ser_req  <= w_ser_req;
            r_grant    <= w_grant;
            r_busy     <= w_busy;
            r_to_err   <= w_to_err;
        end
    end

    assign ack         = r_ack;
    assign ser_data    = r_ser_data;
    assign ser_req     = r_ser_req;
    assign grant       = r_grant;
    assign busy        = r_busy;
    assign timeout_err = r_to_err;

endmodule

// File: tb/tb_rs232_tx_arb.sv
// Self-checking bench for rs232_tx_arb: directed vector table, hand-written corner
// sequences, and randomized traffic against a transaction-level arbitration model.
module tb_rs232_tx_arb;

    localparam int NEVER = 99;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  req_lock;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [7:0]  ser_data;
    logic        ser_req;
    logic        ser_ack;
    logic [3:0]  grant;
    logic        busy;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    rs232_tx_arb #(.N_REQ(4), .TIMEOUT(20), .TO_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_lock   (req_lock),
        .req_data   (req_data),
        .ack        (ack),
        .ser_data   (ser_data),
        .ser_req    (ser_req),
        .ser_ack    (ser_ack),
        .grant      (grant),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req      = '0;
        req_lock = '0;
        req_data = '0;
        ser_ack  = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Called in an ARB cycle with req already driven; returns in the DONE cycle.
    task automatic xfer(input int d, input logic [3:0] eg, input logic [7:0] ed,
                        input bit eto, input int elen, input bit scramble,
                        input bit hold, input string tag);
        int len;
        bit got;
        bit data_ok;
        step();
        chk({tag, "_grant"},   32'(grant),   32'(eg));
        chk({tag, "_data"},    32'(ser_data), 32'(ed));
        chk({tag, "_ser_req"}, 32'(ser_req), 32'd1);
        chk({tag, "_busy"},    32'(busy),    32'd1);
        len     = 0;
        got     = 1'b0;
        data_ok = 1'b1;
        for (int k = 0; k < 40 && !got; k++) begin
            if (ser_req === 1'b1) len++;
            if (ser_data !== ed) data_ok = 1'b0;
            if (scramble) begin
                req_data = $urandom;
                req      = 4'($urandom);
            end
            ser_ack = (k == d);
            step();
            if (ack !== 4'b0000) got = 1'b1;
            if (!(got && hold)) ser_ack = 1'b0;
        end
        chk({tag, "_ack_seen"},  32'(got),         32'd1);
        chk({tag, "_ack"},       32'(ack),         32'(eg));
        chk({tag, "_to_err"},    32'(timeout_err), 32'(eto));
        chk({tag, "_req_low"},   32'(ser_req),     32'd0);
        chk({tag, "_grant_hold"},32'(grant),       32'(eg));
        chk({tag, "_busy_done"}, 32'(busy),        32'd1);
        chk({tag, "_len"},       32'(len),         32'(elen));
        chk({tag, "_frozen"},    32'(data_ok),     32'd1);
    endtask

    // From DONE into ARB: everything idle for one cycle.
    task automatic to_arb(input string tag);
        step();
        ser_ack = 1'b0;
        chk({tag, "_arb_grant"}, 32'(grant),       32'd0);
        chk({tag, "_arb_busy"},  32'(busy),        32'd0);
        chk({tag, "_arb_ack"},   32'(ack),         32'd0);
        chk({tag, "_arb_to"},    32'(timeout_err), 32'd0);
        chk({tag, "_arb_req"},   32'(ser_req),     32'd0);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          d;
        logic [3:0]  exp_grant;
        logic [7:0]  exp_data;
        int          exp_len;
        bit          exp_to;
    } vec_t;

    vec_t vt[7];

    bit         pend[4];
    logic [7:0] by[4];
    bit         lk[4];
    int         m_last;
    bit         m_lock;

    task automatic drive_reqs();
        for (int i = 0; i < 4; i++) begin
            req[i]             = pend[i];
            req_data[8*i +: 8] = by[i];
            req_lock[i]        = lk[i];
        end
    endtask

    initial begin
        // Single transfers from reset: requester 0 has first priority.
        vt[0] = '{4'b0001, 32'h000000AA, 5,     4'b0001, 8'hAA, 6,  1'b0};
        vt[1] = '{4'b0110, 32'h44333C11, 0,     4'b0010, 8'h3C, 1,  1'b0};
        vt[2] = '{4'b1000, 32'hC3000000, 19,    4'b1000, 8'hC3, 20, 1'b0};
        vt[3] = '{4'b0010, 32'h00005A00, NEVER, 4'b0010, 8'h5A, 20, 1'b1};
        vt[4] = '{4'b1100, 32'h77010000, 18,    4'b0100, 8'h01, 19, 1'b0};
        vt[5] = '{4'b1111, 32'hF3F2F1F0, 2,     4'b0001, 8'hF0, 3,  1'b0};
        vt[6] = '{4'b1000, 32'h9E000000, 20,    4'b1000, 8'h9E, 20, 1'b1};

        do_reset();
        chk("rst_ack",      32'(ack),         32'd0);
        chk("rst_ser_data", 32'(ser_data),    32'd0);
        chk("rst_ser_req",  32'(ser_req),     32'd0);
        chk("rst_grant",    32'(grant),       32'd0);
        chk("rst_busy",     32'(busy),        32'd0);
        chk("rst_to_err",   32'(timeout_err), 32'd0);

        for (int v = 0; v < 7; v++) begin
            do_reset();
            req      = vt[v].req;
            req_data = vt[v].data;
            xfer(vt[v].d, vt[v].exp_grant, vt[v].exp_data, vt[v].exp_to,
                 vt[v].exp_len, 1'b0, (v == 2), $sformatf("vec%0d", v));
            req = '0;
            to_arb($sformatf("vec%0d", v));
        end

        // Round-robin with all four requesting.
        do_reset();
        req      = 4'b1111;
        req_data = 32'h13121110;
        for (int n = 0; n < 5; n++) begin
            xfer(3, 4'(1 << (n % 4)), 8'(8'h10 + (n % 4)), 1'b0, 4, 1'b0, 1'b0,
                 $sformatf("rr%0d", n));
            to_arb($sformatf("rr%0d", n));
        end

        // Lock burst by requester 2 while requester 0 also waits.
        do_reset();
        req      = 4'b0010;
        req_data = 32'h00009900;
        xfer(1, 4'b0010, 8'h99, 1'b0, 2, 1'b0, 1'b0, "lk_pre");
        req      = 4'b0101;
        req_lock = 4'b0100;
        req_data = 32'h00550077;
        to_arb("lk_pre");
        xfer(2, 4'b0100, 8'h55, 1'b0, 3, 1'b0, 1'b0, "lk0");
        req_data = 32'h00560077;
        to_arb("lk0");
        xfer(2, 4'b0100, 8'h56, 1'b0, 3, 1'b0, 1'b0, "lk1");
        req_data = 32'h00570077;
        req_lock = 4'b0000;
        to_arb("lk1");
        xfer(2, 4'b0100, 8'h57, 1'b0, 3, 1'b0, 1'b0, "lk2");
        req_data = 32'h00580077;
        to_arb("lk2");
        xfer(2, 4'b0001, 8'h77, 1'b0, 3, 1'b0, 1'b0, "lk_end");
        req = '0;
        to_arb("lk_end");

        // Timeout, then the next arbitration moves past the aborted owner.
        do_reset();
        req      = 4'b0010;
        req_data = 32'h00005A00;
        xfer(NEVER, 4'b0010, 8'h5A, 1'b1, 20, 1'b0, 1'b0, "to");
        req      = 4'b0110;
        req_data = 32'h00665A00;
        to_arb("to");
        xfer(0, 4'b0100, 8'h66, 1'b0, 1, 1'b0, 1'b0, "to_next");
        req = '0;
        to_arb("to_next");

        // Reset in the middle of a transfer.
        do_reset();
        req      = 4'b0010;
        req_data = 32'h0000BB00;
        step();
        chk("ms_ser_req", 32'(ser_req), 32'd1);
        step();
        step();
        rst = 1'b1;
        step();
        rst      = 1'b0;
        req      = 4'b1111;
        req_data = 32'hD3D2D1D0;
        chk("ms_ack",      32'(ack),         32'd0);
        chk("ms_ser_req0", 32'(ser_req),     32'd0);
        chk("ms_grant",    32'(grant),       32'd0);
        chk("ms_busy",     32'(busy),        32'd0);
        chk("ms_to_err",   32'(timeout_err), 32'd0);
        chk("ms_ser_data", 32'(ser_data),    32'd0);
        xfer(1, 4'b0001, 8'hD0, 1'b0, 2, 1'b0, 1'b0, "ms_after");
        req = '0;
        to_arb("ms_after");

        // Randomized traffic against a transaction-level model.
        do_reset();
        m_last = 3;
        m_lock = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pend[i] = 1'($urandom);
            by[i]   = 8'($urandom);
            lk[i]   = 1'($urandom);
        end
        for (int t = 0; t < 150; t++) begin
            int  w;
            int  d;
            bit  eto;
            bit  anyp;
            drive_reqs();
            anyp = pend[0] | pend[1] | pend[2] | pend[3];
            if (!anyp) begin
                step();
                chk("rnd_idle_grant", 32'(grant),   32'd0);
                chk("rnd_idle_req",   32'(ser_req), 32'd0);
                pend[$urandom_range(0, 3)] = 1'b1;
                continue;
            end
            w = -1;
            if (m_lock && pend[m_last]) begin
                w = m_last;
            end else begin
                m_lock = 1'b0;
                for (int i = 1; i <= 4; i++) begin
                    if (w < 0 && pend[(m_last + i) % 4]) w = (m_last + i) % 4;
                end
            end
            d   = ($urandom_range(0, 99) < 10) ? NEVER : int'($urandom_range(0, 21));
            eto = (d >= 20);
            xfer(d, 4'(1 << w), by[w], eto, eto ? 20 : d + 1,
                 1'($urandom), 1'($urandom), $sformatf("rnd%0d", t));
            m_last = w;
            m_lock = eto ? 1'b0 : lk[w];
            pend[w] = ($urandom_range(0, 2) != 0);
            by[w]   = 8'($urandom);
            lk[w]   = 1'($urandom);
            for (int i = 0; i < 4; i++) begin
                if (i != w && !pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    by[i]   = 8'($urandom);
                    lk[i]   = 1'($urandom);
                end
            end
            drive_reqs();
            to_arb($sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rs232_tx_arb.md
Name: rs232_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares one RS232 serializer (byte-wide req/ack transmit datapath) between N_REQ on-chip requesters.
- Each requester presents one byte with a request. The arbiter selects a winner and drives the byte into the serializer with a req/ack handshake. It returns a one-cycle ack to the winner when the serializer accepts the byte.
- Supports locked multi-byte bursts and a stuck-serializer timeout.
- Sits between the command/response logic and the RS232 serializer, mirroring the receive-side deserializer handshake.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 200000, clk cycles to wait for ser_ack before aborting (above one 10-bit frame at 9600 baud on 100 MHz).
- TO_W, 18, width of the timeout counter; must satisfy 2**TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. The design has one clock; reset is synchronous and active-high.
- req  in  N_REQ  per-requester byte-valid; held high with data stable until ack.
- req_lock  in  N_REQ  per-requester: keep the grant after the current byte (burst).
- req_data  in  8*N_REQ  byte i is req_data[8i+7:8i].
- ack  out  N_REQ  one-cycle pulse to the owner when its byte is accepted or aborted.
- ser_data  out  8  byte to the serializer; stable while ser_req=1.
- ser_req  out  1  byte-valid to the serializer.
- ser_ack  in  1  serializer accept pulse (one or more cycles; only the first is counted).
- grant  out  N_REQ  one-hot current owner; all-zero when idle.
- busy  out  1  high whenever the state is not ARB.
- timeout_err  out  1  one-cycle pulse on abort.

Behaviour:
- Reset values: ack=0, ser_data=0, ser_req=0, grant=0, busy=0, timeout_err=0, state=ARB, last=N_REQ-1 (so requester 0 has first priority), lock_own=0, counter=0.
- All outputs are registered.

State ARB:
- If lock_own=1 and req[last]=1, requester last wins regardless of the others.
- Otherwise the winner is the first i with req[i]=1, scanning last+1, last+2, ... modulo N_REQ.
- If there is no winner: stay in ARB with grant=0.
- Else, at the clock edge: grant=onehot(w), ser_data=req_data[w], ser_req=1, counter=0, last=w, state=SEND.
- If lock_own=1 but req[last]=0, clear lock_own and arbitrate normally in the same cycle.

State SEND:
- ser_req stays high and ser_data is frozen; later changes on req_data are ignored.
- Counter increments every cycle.
- On ser_ack=1: ser_req=0, ack[last]=1 for one cycle, lock_own=req_lock[last] sampled in that cycle, state=DONE.
- Else, when counter reaches TIMEOUT-1: ser_req=0, ack[last]=1, timeout_err=1, lock_own=0, state=DONE.
- If ser_ack and the timeout occur in the same cycle, ser_ack wins: no error.

State DONE:
- Exactly one cycle; ack and timeout_err clear; grant is held.
- A ser_ack still asserted is ignored.
- Next state is ARB. In ARB, grant=0 unless a new grant issues.
- Requesters must update req/data in the DONE cycle; ARB samples the updated values.

Throughput and latency:
- Minimum 3 cycles per byte plus serializer time: ARB→SEND edge, ser_ack, DONE.
- Latency from req rising (idle arbiter) to ser_req=1 is 1 cycle.

Other rules:
- Round-robin fairness: no requester waits more than N_REQ-1 grants unless a lock burst is active.
- req deasserted by the owner during SEND is ignored; the byte still completes.
- rst at any state returns everything to reset values at the next edge, including mid-SEND. ser_req drops with no ack issued.

Test Plan:
- Single byte: req=0001, req_data[7:0]=0xAA, ser_ack pulsed 5 cycles after ser_req → ser_data=0xAA, grant=0001, ack=0001 for 1 cycle, ser_req low next cycle, busy low 2 cycles after ack.
- Round-robin: req=1111 held, bytes 0x10/0x11/0x12/0x13, ser_ack 3 cycles after each ser_req → grant order 0,1,2,3,0; ser_data sequence 0x10,0x11,0x12,0x13,0x10.
- Lock burst: requester 2 req_lock=1 for 3 bytes (0x55,0x56,0x57), requester 0 also requesting → serializer sees 0x55,0x56,0x57 and then requester 0's byte; grant stays 0100 for three transfers.
- Timeout: TIMEOUT=20, req=0010, ser_ack never asserted → ser_req high exactly 20 cycles, then ack=0010 and timeout_err=1 together for 1 cycle; the next ARB honours other requesters.
- Simultaneous ser_ack and timeout on cycle 19 (TIMEOUT=20) → ack pulse, timeout_err=0.
- Reset mid-SEND: rst high for 1 cycle while ser_req=1 → all outputs 0 next cycle, no ack pulse; requester 0 wins the first arbitration after reset.
